// File: rtl/ads5296a_pkg.sv
// rtl/ads5296a_pkg.sv - shared constants and mode encoding for the ADS5296A TX emulator
package ads5296a_pkg;

    localparam int SAMPLE_BITS = 10;

    // Frame-clock lane word: five ones then five zeros, MSB first
    localparam logic [SAMPLE_BITS-1:0] FRAME_PATTERN = 10'h3E0;
    localparam logic [SAMPLE_BITS-1:0] DESKEW        = 10'h155;
    localparam logic [SAMPLE_BITS-1:0] SYNC_WORD     = 10'h3E0;

    typedef enum logic [2:0] {
        MODE_NORMAL = 3'd0,
        MODE_ZEROS  = 3'd1,
        MODE_DESKEW = 3'd2,
        MODE_SYNC   = 3'd3,
        MODE_RAMP   = 3'd4,
        MODE_CUSTOM = 3'd5
    } mode_e;

endpackage

// File: rtl/ads5296a_tx_emulator_if.sv
// rtl/ads5296a_tx_emulator_if.sv - sample handshake bundle feeding the TX emulator
interface ads5296a_tx_emulator_if #(
    parameter int N_LANES     = 8,
    parameter int SAMPLE_BITS = 10
);
    // Lane k occupies sample[k*SAMPLE_BITS +: SAMPLE_BITS]
    logic [N_LANES*SAMPLE_BITS-1:0] sample;
    logic                           sample_valid;
    logic                           sample_ready;

    modport master (
        output sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/ads5296a_tx_emulator_lane_ser.sv
// rtl/ads5296a_tx_emulator_lane_ser.sv - one lane: prev/cur words, bit-delay shift and DDR phase mux
module ads5296a_lane_ser #(
    parameter int SAMPLE_BITS = 10,
    parameter int PH_W        = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic                   load_i,
    input  logic                   hold_i,
    input  logic [SAMPLE_BITS-1:0] word_i,
    input  logic [3:0]             offset_i,
    input  logic [PH_W-1:0]        phase_i,
    output logic                   rise_o,
    output logic                   fall_o
);
    localparam int IDX_W = $clog2(SAMPLE_BITS);

    logic [SAMPLE_BITS-1:0] prev_q, prev_d;
    logic [SAMPLE_BITS-1:0] cur_q, cur_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [SAMPLE_BITS-1:0] tword;
    logic [IDX_W-1:0]       rise_idx;
    logic [IDX_W-1:0]       fall_idx;

    // Delayed word view, bit selection for this phase, and word pipeline next state
    always_comb begin
        // Shifting the two-word window right by d delays the stream by d bits
        tword    = SAMPLE_BITS'({prev_q, cur_q} >> offset_i);
        rise_idx = IDX_W'(SAMPLE_BITS - 1) - IDX_W'({phase_i, 1'b0});
        fall_idx = rise_idx - IDX_W'(1);
        rise_d   = en_i & tword[rise_idx];
        fall_d   = en_i & tword[fall_idx];

        prev_d = prev_q;
        cur_d  = cur_q;
        if (!en_i) begin
            prev_d = '0;
            cur_d  = '0;
        end else if (load_i) begin
            prev_d = cur_q;
            if (!hold_i) begin
                cur_d = word_i;
            end
        end
    end

    // Word registers and registered DDR bit pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            cur_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cur_q  <= cur_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ads5296a_tx_emulator.sv
// rtl/ads5296a_tx_emulator.sv - ADS5296A serial LVDS output emulator (data lanes plus frame lane)
module ads5296a_tx_emulator #(
    parameter int N_LANES     = 8,
    parameter int SAMPLE_BITS = ads5296a_pkg::SAMPLE_BITS,
    parameter int UFLOW_W     = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   en_i,
    input  logic [2:0]             mode_i,
    input  logic [SAMPLE_BITS-1:0] custom_pattern_i,
    input  logic [3:0]             bit_offset_i,
    ads5296a_tx_emulator_if.slave  smp,
    output logic [N_LANES:0]       dout_rise_o,
    output logic [N_LANES:0]       dout_fall_o,
    output logic                   frame_start_o,
    output logic [UFLOW_W-1:0]     underflow_cnt_o,
    input  logic                   underflow_clr_i
);
    import ads5296a_pkg::*;

    localparam int              PHASES     = SAMPLE_BITS / 2;
    localparam int              PH_W       = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PHASES - 1);
    localparam logic [3:0]      MAX_OFFSET = 4'(SAMPLE_BITS - 1);

    mode_e                  mode;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [3:0]             offset_q, offset_d;
    logic [SAMPLE_BITS-1:0] ramp_q, ramp_d;
    logic [UFLOW_W-1:0]     uflow_q, uflow_d;
    logic                   frame_start_q, frame_start_d;
    logic                   boundary;
    logic                   is_normal;
    logic                   hold;
    logic [SAMPLE_BITS-1:0] test_word;

    assign mode = mode_e'(mode_i);

    // Boundary decode, pattern selection and next state of the shared counters.
    // mode_i and custom_pattern_i are consumed only on the boundary cycle, so a
    // mid-frame change can only take effect on the following frame.
    always_comb begin
        boundary  = en_i && (phase_q == LAST_PHASE);
        is_normal = (mode == MODE_NORMAL);
        hold      = is_normal && !smp.sample_valid;

        case (mode)
            MODE_DESKEW: test_word = SAMPLE_BITS'(DESKEW);
            MODE_SYNC:   test_word = SAMPLE_BITS'(SYNC_WORD);
            MODE_RAMP:   test_word = ramp_q;
            MODE_CUSTOM: test_word = custom_pattern_i;
            default:     test_word = '0;
        endcase

        if (!en_i || boundary) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end

        offset_d = offset_q;
        if (boundary) begin
            offset_d = (bit_offset_i > MAX_OFFSET) ? MAX_OFFSET : bit_offset_i;
        end

        ramp_d = ramp_q;
        if (boundary && mode == MODE_RAMP) begin
            ramp_d = ramp_q + SAMPLE_BITS'(1);
        end

        // Clear wins over a same-cycle miss
        uflow_d = uflow_q;
        if (underflow_clr_i) begin
            uflow_d = '0;
        end else if (boundary && hold && (uflow_q != '1)) begin
            uflow_d = uflow_q + UFLOW_W'(1);
        end

        frame_start_d = en_i && (phase_q == '0);
    end

    // Phase, latched offset, ramp and underflow state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_q       <= '0;
            offset_q      <= '0;
            ramp_q        <= '0;
            uflow_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            offset_q      <= offset_d;
            ramp_q        <= ramp_d;
            uflow_q       <= uflow_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign smp.sample_ready = boundary;
    assign frame_start_o    = frame_start_q;
    assign underflow_cnt_o  = uflow_q;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        ads5296a_lane_ser #(
            .SAMPLE_BITS (SAMPLE_BITS),
            .PH_W        (PH_W)
        ) u_lane (
            .clk      (sys_clk),
            .rst_n    (sys_rst_n),
            .en_i     (en_i),
            .load_i   (boundary),
            .hold_i   (hold),
            .word_i   (is_normal ? smp.sample[k*SAMPLE_BITS +: SAMPLE_BITS] : test_word),
            .offset_i (offset_q),
            .phase_i  (phase_q),
            .rise_o   (dout_rise_o[k]),
            .fall_o   (dout_fall_o[k])
        );
    end

    // Frame lane shares the offset so the receiver sees the whole bundle delayed together
    ads5296a_lane_ser #(
        .SAMPLE_BITS (SAMPLE_BITS),
        .PH_W        (PH_W)
    ) u_frame_lane (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .en_i     (en_i),
        .load_i   (boundary),
        .hold_i   (1'b0),
        .word_i   (SAMPLE_BITS'(FRAME_PATTERN)),
        .offset_i (offset_q),
        .phase_i  (phase_q),
        .rise_o   (dout_rise_o[N_LANES]),
        .fall_o   (dout_fall_o[N_LANES])
    );

endmodule

// File: doc/ads5296a_tx_emulator.md
Name: ads5296a_tx_emulator

Overview:
Synthesizable emulator of the ADS5296A 10-bit serial LVDS output, used for loopback tests of the ADS5296A receiver/deserializer and its bitslip alignment.
- Serializes one 10-bit sample per lane per frame, MSB first, DDR: two bits per clock on rise/fall outputs that feed ODDR primitives.
- Generates the frame-clock lane (pattern 1111100000).
- Supports test patterns and a programmable whole-stream bit delay to exercise receiver alignment.

Parameters:
N_LANES, 8, number of data lanes.
SAMPLE_BITS, 10, bits per sample; must be even. PHASES = SAMPLE_BITS/2 clocks per frame.
UFLOW_W, 16, width of the underflow counter.

Ports:
sys_clk  in  1  bit-pair clock, one cycle per 2 serial bits (5x sample rate).
sys_rst_n  in  1  asynchronous, active-low reset.
en_i  in  1  transmit enable.
mode_i  in  3  0 normal, 1 zeros, 2 deskew 0x155, 3 sync 0x3E0, 4 ramp, 5 custom; 6-7 behave as zeros.
custom_pattern_i  in  SAMPLE_BITS  word used for mode 5.
bit_offset_i  in  4  stream delay in bits, 0..9; values above 9 clamp to 9.
sample_i  in  N_LANES*SAMPLE_BITS  lane k occupies bits [k*10+9:k*10].
sample_valid_i  in  1  sample handshake valid.
sample_ready_o  out  1  sample handshake ready.
dout_rise_o  out  N_LANES+1  bit sent on the LCLK rising edge; index N_LANES is the frame lane.
dout_fall_o  out  N_LANES+1  bit sent on the LCLK falling edge.
frame_start_o  out  1  high while outputs carry phase 0 of a frame.
underflow_cnt_o  out  UFLOW_W  saturating count of missed samples (normal mode only).
underflow_clr_i  in  1  synchronous clear of the underflow counter.

Behaviour:
Reset:
- All outputs 0.
- Phase counter, ramp counter, and all prev/cur lane words 0.
- Latched mode, offset, and custom pattern 0.

Frame timing:
- While en_i=1, the phase counter p counts 0..PHASES-1 and wraps.
- en_i=0: p forced to 0, prev/cur cleared, ready low, outputs 0.
- sample_ready_o = en_i && (p == PHASES-1). Nothing else gates it.

Boundary cycle (p = PHASES-1), all loaded together:
- prev <= cur for every lane.
- mode_i, bit_offset_i, custom_pattern_i are latched. Mid-frame changes never affect the frame in flight.
- New cur per lane is selected as follows:
  - normal + valid: load sample_i.
  - normal + no valid: keep the old cur and increment underflow_cnt_o, saturating at all-ones.
  - test modes: load the pattern word; any offered sample is accepted and discarded.
  - ramp: every lane gets the ramp counter, which then increments modulo 1024.
  - frame lane: cur is always 0x3E0.
- underflow_clr_i has priority over an increment in the same cycle.

Serialization:
- Per lane, T = ({prev,cur} >> d)[9:0], where d is the latched offset. This delays the whole stream, frame lane included, by d bits.
- At phase p: rise = T[9-2p], fall = T[8-2p].
- Outputs are registered: pair for phase p appears the cycle after the counter holds p.
- A sample accepted at cycle t has its MSB pair visible at t+2 (d=0). frame_start_o is aligned to that pair.

Reset mid-frame:
- Asynchronous return to reset state.
- After release, the first boundary occurs PHASES-1 cycles after the counter leaves 0.

Decomposition:
- Shared package ads5296a_pkg holds:
  - SAMPLE_BITS;
  - FRAME_PATTERN 0x3E0, DESKEW 0x155;
  - the mode enum constants (MODE_NORMAL … MODE_CUSTOM).
- One natural sub-module: ads5296a_lane_ser, holding the prev/cur registers, offset barrel shift, and phase mux. It is instantiated N_LANES+1 times; the frame lane is tied to FRAME_PATTERN.

Test Plan:
1. Reset + en_i=1, d=0, normal, lane0 sample 0x2AB:
   - lane0 rise/fall pairs (1,0),(1,0),(1,0),(1,0),(1,1).
   - frame lane pairs (1,1),(1,1),(1,0),(0,0),(0,0), with frame_start_o on the first pair.
2. Offset: d=3, mode 3, steady state:
   - every lane and the frame lane carry 0x07C: pairs (0,0),(0,1),(1,1),(1,1),(0,0).
   - A receiver model realigns with 3-bit bitslip.
3. Underflow: withhold valid for 3 boundaries:
   - last sample repeats each frame; underflow_cnt_o = 3.
   - underflow_clr_i together with a 4th miss leaves 0.
4. Ramp from reset:
   - frames carry 0,1,2… on all lanes; after 1024 frames the value wraps 1023 -> 0.
   - no underflow counted with valid low.
5. Mode 0 -> 2 written at p=2:
   - the current frame still carries the sample.
   - the next frame carries 0x155, pairs (0,1) x5.
6. sys_rst_n pulsed low at p=3:
   - outputs 0 immediately.
   - after release the first ready occurs 4 cycles later; no stale data is emitted.
